// File: rtl/cp0_timer_intc.sv
`default_nettype none
// ============================================================================
// Module   : cp0_timer_intc
// Brief    : CP0 register file with Count/Compare timer, BadVAddr, synchronised
//            external interrupts and interrupt-request generation.
// Revision : 1.0 - initial release
// ============================================================================
module cp0_timer_intc #(
    parameter int NUM_HW_INT  = 6,
    parameter int COUNT_DIV   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mtc0_we,
    input  logic [7:0]            cp0r_addr,
    input  logic [31:0]           c0_wdata,
    input  logic                  wb_ex,
    input  logic                  wb_bd,
    input  logic [4:0]            wb_excode,
    input  logic [31:0]           wb_pc,
    input  logic [31:0]           wb_badvaddr,
    input  logic                  eret_flush,
    input  logic [NUM_HW_INT-1:0] ext_int_in,
    output logic [31:0]           rdata,
    output logic [31:0]           c0_epc,
    output logic                  int_req
);

    localparam int              c_PW        = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(COUNT_DIV - 1);
    localparam logic [4:0]      c_REG_BADV  = 5'd8;
    localparam logic [4:0]      c_REG_COUNT = 5'd9;
    localparam logic [4:0]      c_REG_CMP   = 5'd11;
    localparam logic [4:0]      c_REG_STAT  = 5'd12;
    localparam logic [4:0]      c_REG_CAUSE = 5'd13;
    localparam logic [4:0]      c_REG_EPC   = 5'd14;

    logic [4:0]            w_reg;
    logic                  w_sel0;
    logic                  w_mtc0;
    logic                  w_wr_count, w_wr_cmp, w_wr_stat, w_wr_cause, w_wr_epc;
    logic [c_PW-1:0]       r_presc;
    logic [31:0]           r_count;
    logic [31:0]           r_compare;
    logic                  r_inc_d;
    logic                  r_ti;
    logic [NUM_HW_INT-1:0] r_sync [SYNC_STAGES];
    logic [NUM_HW_INT-1:0] r_ip_hw;
    logic [5:0]            w_hw6;
    logic [7:0]            w_ip;
    logic                  r_ie, r_exl, r_bd;
    logic [7:0]            r_im;
    logic [1:0]            r_ip_sw;
    logic [4:0]            r_excode;
    logic [31:0]           r_epc;
    logic [31:0]           r_badvaddr;

    assign w_reg  = cp0r_addr[7:3];
    assign w_sel0 = (cp0r_addr[2:0] == 3'd0);
    // Exception and ERET commits pre-empt a same-cycle MTC0.
    assign w_mtc0     = mtc0_we & ~wb_ex & ~eret_flush & w_sel0;
    assign w_wr_count = w_mtc0 & (w_reg == c_REG_COUNT);
    assign w_wr_cmp   = w_mtc0 & (w_reg == c_REG_CMP);
    assign w_wr_stat  = w_mtc0 & (w_reg == c_REG_STAT);
    assign w_wr_cause = w_mtc0 & (w_reg == c_REG_CAUSE);
    assign w_wr_epc   = w_mtc0 & (w_reg == c_REG_EPC);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
            r_count <= '0;
            r_inc_d <= 1'b0;
        end else if (w_wr_count) begin
            r_presc <= '0;
            r_count <= c0_wdata;
            r_inc_d <= 1'b0;
        end else if (r_presc == c_PRESC_MAX) begin
            r_presc <= '0;
            r_count <= r_count + 32'd1;
            r_inc_d <= 1'b1;
        end else begin
            r_presc <= r_presc + c_PW'(1);
            r_inc_d <= 1'b0;
        end
    end

    // TI only rises on the cycle after an increment, so a Count load never sets it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_compare <= '0;
            r_ti      <= 1'b0;
        end else begin
            if (w_wr_cmp) begin
                r_compare <= c0_wdata;
                r_ti      <= 1'b0;
            end else if (r_inc_d && (r_count == r_compare)) begin
                r_ti <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
            r_ip_hw <= '0;
        end else begin
            r_sync[0] <= ext_int_in;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
            r_ip_hw <= r_sync[SYNC_STAGES-1];
        end
    end

    generate
        if (NUM_HW_INT == 6) begin : g_full_hw
            assign w_hw6 = r_ip_hw;
        end else begin : g_part_hw
            assign w_hw6 = {{(6-NUM_HW_INT){1'b0}}, r_ip_hw};
        end
    endgenerate

    assign w_ip = {w_hw6[5] | r_ti, w_hw6[4:0], r_ip_sw};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ie       <= 1'b0;
            r_exl      <= 1'b0;
            r_im       <= '0;
            r_bd       <= 1'b0;
            r_excode   <= '0;
            r_ip_sw    <= '0;
            r_epc      <= '0;
            r_badvaddr <= '0;
        end else begin
            if (wb_ex) begin
                r_exl    <= 1'b1;
                r_excode <= wb_excode;
                if (!r_exl) begin
                    r_bd  <= wb_bd;
                    r_epc <= wb_bd ? (wb_pc - 32'd4) : wb_pc;
                end
            end else if (eret_flush) begin
                r_exl <= 1'b0;
            end else begin
                if (w_wr_stat) begin
                    r_im  <= c0_wdata[15:8];
                    r_exl <= c0_wdata[1];
                    r_ie  <= c0_wdata[0];
                end
                if (w_wr_cause) r_ip_sw <= c0_wdata[9:8];
                if (w_wr_epc)   r_epc   <= c0_wdata;
            end
            if (wb_ex && ((wb_excode == 5'd4) || (wb_excode == 5'd5)))
                r_badvaddr <= wb_badvaddr;
        end
    end

    always_comb begin
        rdata = '0;
        if (w_sel0) begin
            case (w_reg)
                c_REG_BADV:  rdata = r_badvaddr;
                c_REG_COUNT: rdata = r_count;
                c_REG_CMP:   rdata = r_compare;
                c_REG_STAT:  rdata = {9'b0, 1'b1, 6'b0, r_im, 6'b0, r_exl, r_ie};
                c_REG_CAUSE: rdata = {r_bd, r_ti, 14'b0, w_ip, 1'b0, r_excode, 2'b0};
                c_REG_EPC:   rdata = r_epc;
                default:     rdata = '0;
            endcase
        end
    end

    assign c0_epc  = r_epc;
    assign int_req = r_ie & ~r_exl & (|(w_ip & r_im));

endmodule
`default_nettype wire
